// File: rtl/axi_burst_master.sv
// axi_burst_master: CPU request port to one AXI4 master slot, INCR bursts of
// up to MAX_BEATS beats, one outstanding transaction.
// Optional feature macro: AXI_BURST_MASTER_ERR_EN (sticky response/beat-count error flag).
module axi_burst_master #(
  parameter int unsigned ID_VAL         = 0,
  parameter int unsigned MAX_BEATS      = 4,
  parameter int unsigned LEN_W          = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
  // Interconnect widths, mirroring the shared AXI define set
  parameter int unsigned AXI_ID_BITS    = 4,
  parameter int unsigned AXI_ADDR_BITS  = 32,
  parameter int unsigned AXI_DATA_BITS  = 32,
  parameter int unsigned AXI_STRB_BITS  = 4,
  parameter int unsigned AXI_LEN_BITS   = 4,
  parameter int unsigned AXI_SIZE_BITS  = 3,
  parameter int unsigned AXI_BURST_BITS = 2,
  parameter int unsigned AXI_RESP_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // CPU request channel
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AXI_ADDR_BITS-1:0]  req_addr,
  input  logic [LEN_W-1:0]          req_len,
  // write data stream
  input  logic                      wd_valid,
  output logic                      wd_ready,
  input  logic [AXI_DATA_BITS-1:0]  wd_data,
  input  logic [AXI_STRB_BITS-1:0]  wd_strb,
  // read data stream
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [AXI_DATA_BITS-1:0]  rd_data,
  output logic                      rd_last,
  // status
  output logic                      done,
  output logic                      err,
  // AXI read address
  output logic [AXI_ID_BITS-1:0]    ARID,
  output logic [AXI_ADDR_BITS-1:0]  ARADDR,
  output logic [AXI_LEN_BITS-1:0]   ARLEN,
  output logic [AXI_SIZE_BITS-1:0]  ARSIZE,
  output logic [AXI_BURST_BITS-1:0] ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // AXI read data
  input  logic [AXI_ID_BITS-1:0]    RID,
  input  logic [AXI_DATA_BITS-1:0]  RDATA,
  input  logic [AXI_RESP_BITS-1:0]  RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  // AXI write address
  output logic [AXI_ID_BITS-1:0]    AWID,
  output logic [AXI_ADDR_BITS-1:0]  AWADDR,
  output logic [AXI_LEN_BITS-1:0]   AWLEN,
  output logic [AXI_SIZE_BITS-1:0]  AWSIZE,
  output logic [AXI_BURST_BITS-1:0] AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // AXI write data
  output logic [AXI_DATA_BITS-1:0]  WDATA,
  output logic [AXI_STRB_BITS-1:0]  WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  // AXI write response
  input  logic [AXI_ID_BITS-1:0]    BID,
  input  logic [AXI_RESP_BITS-1:0]  BRESP,
  input  logic                      BVALID,
  output logic                      BREADY
);

  localparam int unsigned CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_e;

  state_e                   state_q, state_d;
  logic                     init_q;
  logic                     done_q;
  logic [AXI_ADDR_BITS-1:0] addr_q;
  logic [LEN_W-1:0]         len_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     accept, r_hs, w_hs, b_hs, last_beat;

  assign accept    = req_valid && req_ready;
  assign r_hs      = RVALID && RREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign last_beat = (cnt_q == CNT_W'(len_q));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)         state_d = req_we ? S_AW : S_AR;
      S_AR:    if (ARREADY)        state_d = S_R;
      S_R:     if (r_hs && RLAST)  state_d = S_IDLE;
      S_AW:    if (AWREADY)        state_d = S_W;
      S_W:     if (w_hs && WLAST)  state_d = S_B;
      S_B:     if (b_hs)           state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output decode; streams pass through only in their data state
  always_comb begin
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    AWVALID   = 1'b0;
    rd_valid  = 1'b0;
    RREADY    = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    WVALID    = 1'b0;
    wd_ready  = 1'b0;
    WDATA     = '0;
    WSTRB     = '0;
    WLAST     = 1'b0;
    BREADY    = 1'b0;
    unique case (state_q)
      S_IDLE: req_ready = init_q;
      S_AR:   ARVALID   = 1'b1;
      S_R: begin
        rd_valid = RVALID;
        RREADY   = rd_ready;
        rd_data  = RDATA;
        rd_last  = RLAST;
      end
      S_AW:   AWVALID   = 1'b1;
      S_W: begin
        WVALID   = wd_valid;
        wd_ready = WREADY;
        WDATA    = wd_data;
        WSTRB    = wd_strb;
        WLAST    = last_beat;
      end
      S_B:    BREADY    = 1'b1;
      default: ;
    endcase
  end

  // Fixed address-channel fields, driven from the latched request
  assign ARID    = AXI_ID_BITS'(ID_VAL);
  assign AWID    = AXI_ID_BITS'(ID_VAL);
  assign ARADDR  = addr_q;
  assign AWADDR  = addr_q;
  assign ARLEN   = AXI_LEN_BITS'(len_q);
  assign AWLEN   = AXI_LEN_BITS'(len_q);
  assign ARSIZE  = AXI_SIZE_BITS'(3'b010);
  assign AWSIZE  = AXI_SIZE_BITS'(3'b010);
  assign ARBURST = AXI_BURST_BITS'(2'b01);
  assign AWBURST = AXI_BURST_BITS'(2'b01);
  assign done    = done_q;

  // Request latch, beat counter (saturating) and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      init_q <= 1'b1;
      done_q <= (r_hs && RLAST) || b_hs;
      if (accept) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        cnt_q  <= '0;
      end else if ((r_hs || w_hs) && (cnt_q != '1)) begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef AXI_BURST_MASTER_ERR_EN
  logic err_q;
  logic err_set;
  logic unused_ok;

  assign err_set   = (r_hs && (RRESP != '0)) || (b_hs && (BRESP != '0)) ||
                     (r_hs && RLAST && !last_beat);
  assign err       = err_q;
  assign unused_ok = ^{RID, BID};

  // Sticky error, cleared when the next request is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
`else
  logic unused_ok;

  assign err       = 1'b0;
  assign unused_ok = ^{RID, BID, RRESP, BRESP};
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with data scoreboards on R and W.
module tb_axi_burst_master;

  localparam int unsigned LEN_W = 2;
`ifdef AXI_BURST_MASTER_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, err;
  logic [3:0]  ARID, AWID, RID, BID, ARLEN, AWLEN;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [3:0]  WSTRB;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] sb_data[$];
  logic        sb_last[$];
  logic [3:0]  sb_strb[$];
  logic [31:0] wdat [4];
  logic [3:0]  wstb [4];

  axi_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int last_at,
                         input int stall_beat, input logic [1:0] resp, input logic [31:0] seed);
    logic [31:0] d;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = LEN_W'(len);
    #1;
    chk("rd_req_ready", 32'(req_ready), 32'd1);
    chk("ar_not_at_accept", 32'(ARVALID), 32'd0);
    tick();
    req_valid = 1'b0;
    RVALID = 1'b1; rd_ready = 1'b1; RDATA = 32'hBAD0_BAD0;
    #1;
    chk("arvalid", 32'(ARVALID), 32'd1);
    chk("araddr", ARADDR, addr);
    chk("arlen", 32'(ARLEN), 32'(len));
    chk("arsize", 32'(ARSIZE), 32'd2);
    chk("arburst", 32'(ARBURST), 32'd1);
    chk("rd_valid_in_ar", 32'(rd_valid), 32'd0);
    chk("rready_in_ar", 32'(RREADY), 32'd0);
    chk("err_clr_on_accept", 32'(err), 32'd0);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      d = seed + 32'(b) * 32'h0101_0101;
      RVALID = 1'b1; RDATA = d; RLAST = (b == last_at); RRESP = resp;
      sb_data.push_back(d);
      sb_last.push_back(b == last_at);
      if (b == stall_beat) begin
        rd_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          #1;
          chk("rready_follows_low", 32'(RREADY), 32'd0);
          chk("rd_valid_stall", 32'(rd_valid), 32'd1);
          tick();
        end
      end
      rd_ready = 1'b1;
      #1;
      chk("rready_follows_high", 32'(RREADY), 32'd1);
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", rd_data, sb_data.pop_front());
      chk("rd_last", 32'(rd_last), 32'(sb_last.pop_front()));
      chk("rd_no_done_early", 32'(done), 32'd0);
      tick();
    end
    RVALID = 1'b0; RLAST = 1'b0; rd_ready = 1'b0; RRESP = 2'b00;
    #1;
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_idle_ready", 32'(req_ready), 32'd1);
    chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    tick();
    chk("rd_done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int aw_delay,
                          input int gap_beat, input logic [1:0] bresp);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = LEN_W'(len);
    #1;
    chk("wr_req_ready", 32'(req_ready), 32'd1);
    chk("aw_not_at_accept", 32'(AWVALID), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("err_clr_on_accept", 32'(err), 32'd0);
    wd_valid = 1'b1; wd_data = wdat[0]; wd_strb = wstb[0]; WREADY = 1'b1;
    for (int d = 0; d < aw_delay; d++) begin
      #1;
      chk("awvalid_hold", 32'(AWVALID), 32'd1);
      chk("awaddr_hold", AWADDR, addr);
      chk("no_w_before_aw", 32'(WVALID), 32'd0);
      chk("no_wd_ready_before_aw", 32'(wd_ready), 32'd0);
      tick();
    end
    AWREADY = 1'b1;
    #1;
    chk("awvalid", 32'(AWVALID), 32'd1);
    chk("awaddr", AWADDR, addr);
    chk("awlen", 32'(AWLEN), 32'(len));
    chk("awsize", 32'(AWSIZE), 32'd2);
    chk("awburst", 32'(AWBURST), 32'd1);
    tick();
    AWREADY = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == gap_beat) begin
        wd_valid = 1'b0;
        #1;
        chk("w_gap", 32'(WVALID), 32'd0);
        tick();
      end
      wd_valid = 1'b1; wd_data = wdat[b]; wd_strb = wstb[b];
      sb_data.push_back(wdat[b]);
      sb_strb.push_back(wstb[b]);
      sb_last.push_back(b == len);
      #1;
      chk("wvalid", 32'(WVALID), 32'd1);
      chk("wd_ready", 32'(wd_ready), 32'd1);
      chk("wdata", WDATA, sb_data.pop_front());
      chk("wstrb", 32'(WSTRB), 32'(sb_strb.pop_front()));
      chk("wlast", 32'(WLAST), 32'(sb_last.pop_front()));
      tick();
    end
    wd_valid = 1'b0; WREADY = 1'b0;
    #1;
    chk("wvalid_in_b", 32'(WVALID), 32'd0);
    chk("bready", 32'(BREADY), 32'd1);
    chk("wr_no_done_early", 32'(done), 32'd0);
    BVALID = 1'b1; BRESP = bresp;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    #1;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_idle_ready", 32'(req_ready), 32'd1);
    tick();
    chk("wr_done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
    ARREADY = 1'b0; RID = 4'h3; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = 4'h5; BRESP = '0; BVALID = 1'b0;

    // reset values
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_wvalid", 32'(WVALID), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk("rst_awlen", 32'(AWLEN), 32'd0);
    #9 rst_n = 1'b1;
    #1;
    chk("req_ready_at_release", 32'(req_ready), 32'd0);
    tick();
    chk("req_ready_after_release", 32'(req_ready), 32'd1);

    // single read
    do_read(32'h0000_0100, 0, 0, -1, 2'b00, 32'hDEAD_BEEF);
    chk("single_rd_err", 32'(err), 32'd0);

    // 4-beat read with rd_ready backpressure on beat 1
    do_read(32'h0000_0400, 3, 3, 1, 2'b00, 32'h1000_0000);
    chk("burst_rd_err", 32'(err), 32'd0);

    // 2-beat write
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b1111;
    wdat[1] = 32'hAABB_CCDD; wstb[1] = 4'b0011;
    do_write(32'h0000_2000, 1, 0, -1, 2'b00);
    chk("wr2_err", 32'(err), 32'd0);

    // slow AW slave, 4-beat write with a wd_valid gap on beat 2
    wdat[0] = 32'h0000_0001; wstb[0] = 4'b0001;
    wdat[1] = 32'h0000_0202; wstb[1] = 4'b0010;
    wdat[2] = 32'h0003_0303; wstb[2] = 4'b0100;
    wdat[3] = 32'h0404_0404; wstb[3] = 4'b1000;
    do_write(32'h0000_3000, 3, 5, 2, 2'b00);
    chk("wr4_err", 32'(err), 32'd0);

    // BRESP=SLVERR, then cleared at next acceptance (checked inside do_read)
    wdat[0] = 32'hCAFE_F00D; wstb[0] = 4'b1111;
    do_write(32'h0000_4000, 0, 0, -1, 2'b10);
    chk("bresp_err", 32'(err), 32'(ERR_ON));

    // early RLAST on beat 2 of a len-3 read
    do_read(32'h0000_5000, 3, 1, -1, 2'b00, 32'h5555_0000);
    chk("early_rlast_err", 32'(err), 32'(ERR_ON));
    chk("early_rlast_idle", 32'(req_ready), 32'd1);

    // excess beat: len 1 but RLAST only on beat 3
    do_read(32'h0000_6000, 1, 2, -1, 2'b00, 32'h6666_0000);
    chk("excess_beat_err", 32'(err), 32'(ERR_ON));

    // RRESP error on a clean-length read
    do_read(32'h0000_7000, 1, 1, -1, 2'b10, 32'h7777_0000);
    chk("rresp_err", 32'(err), 32'(ERR_ON));

    // clean read clears the flag
    do_read(32'h0000_8000, 2, 2, -1, 2'b00, 32'h8888_0000);
    chk("clean_rd_err", 32'(err), 32'd0);

    // reset during beat 2 of a 4-beat write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_9000; req_len = 2'd3;
    tick();
    req_valid = 1'b0; AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0; WREADY = 1'b1;
    wd_valid = 1'b1; wd_data = 32'h9000_0000; wd_strb = 4'hF;
    tick();
    wd_data = 32'h9000_0001;
    #1;
    chk("mid_wvalid_before_rst", 32'(WVALID), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", 32'(WVALID), 32'd0);
    chk("mid_rst_wd_ready", 32'(wd_ready), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_awaddr", AWADDR, 32'd0);
    wd_valid = 1'b0; WREADY = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_wvalid", 32'(WVALID), 32'd0);

    // read works after mid-burst reset
    do_read(32'h0000_A000, 0, 0, -1, 2'b00, 32'h0BAD_CAFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised AXI4 master port adapter between a CPU memory-side request interface and one AXI master slot on the interconnect. It succeeds the fixed single-beat, dual-port CPU bridge. Each instance serves one port, so the IF fetch path and the MEM load/store path each get their own instance. It adds configurable burst length, active-high byte strobes, backpressure on both data streams, and response-error reporting.

## Interface
Parameters:
- `ID_VAL`, default 0: constant driven on ARID/AWID.
- `MAX_BEATS`, default 4: maximum burst length; must be a power of two, 1..16.
- `LEN_W`, default `$clog2(MAX_BEATS)` (minimum 1): width of `req_len`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- CPU request channel:
  - `req_valid` in 1, `req_ready` out 1: request handshake.
  - `req_we` in 1: 1 = write, 0 = read.
  - `req_addr` in `AXI_ADDR_BITS`: word-aligned start address.
  - `req_len` in LEN_W: number of beats minus 1.
- Write data stream, CPU to block:
  - `wd_valid` in 1, `wd_ready` out 1: beat handshake.
  - `wd_data` in `AXI_DATA_BITS`.
  - `wd_strb` in `AXI_STRB_BITS`: active high, 1 = byte written.
- Read data stream, block to CPU:
  - `rd_valid` out 1, `rd_ready` in 1: beat handshake.
  - `rd_data` out `AXI_DATA_BITS`.
  - `rd_last` out 1: marks the final beat.
- Status:
  - `done` out 1: one-cycle pulse when a transaction completes.
  - `err` out 1: see Configuration.
- AXI master side: full AW/W/B/AR/R channel set, with widths from `AXI_define.svh`.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - AR: `ARVALID`=1.
  - R: data passes through.
  - AW: `AWVALID`=1.
  - W: `WVALID` mirrors `wd_valid`.
  - B: `BREADY`=1.
- Request capture: on `req_valid && req_ready`, latch `addr`, `len` and `we`, clear the beat counter, then go to AW if `we`=1, otherwise AR.
- Fixed AR/AW fields:
  - `AxLEN` = latched len, zero-extended to `AXI_LEN_BITS`.
  - `AxSIZE` = 3'b010.
  - `AxBURST` = INCR.
  - `AxADDR` = latched addr.
  - All of these are held stable while `AxVALID` is high.
- AR → R and AW → W on the address handshake.
- Read path, pass-through:
  - `rd_valid` = `RVALID`; `RREADY` = `rd_ready`.
  - `rd_data` = `RDATA`; `rd_last` = `RLAST`.
  - Only in state R; all are 0 outside R.
- Read completion: on an R handshake with `RLAST`=1 → IDLE and `done`=1 the next cycle.
- Write path:
  - `WVALID` = `wd_valid`; `wd_ready` = `WREADY`; `WDATA`/`WSTRB` = `wd_data`/`wd_strb`.
  - Only in state W.
  - `WLAST` = (beat counter == latched len).
  - Each W handshake increments the counter.
  - The handshake carrying `WLAST` → B.
- Write completion: on the B handshake → IDLE and `done`=1 the next cycle.
- The beat counter is LEN_W+1 bits wide, so it does not wrap for len = MAX_BEATS-1.
- The block ignores `RID`/`BID`; it has only one outstanding transaction.

## Timing
- Reset values: every AXI `*VALID`/`*READY`, `req_ready`, `wd_ready`, `rd_valid`, `done` and `err` are 0. Address, len and data outputs are 0.
- `req_ready` is high from the first cycle after reset deassertion.
- A request is accepted at edge N; `AxVALID` is high in cycle N+1, never in the same cycle as acceptance.
- Minimum read latency: with a slave that responds immediately, request to first `rd_valid` is 2 cycles.
- Once high, `AxVALID` stays high until its handshake, whatever the slave does.
- Completion sequence: the final R/B handshake occurs at edge M. `done`=1 during cycle M+1 and `req_ready`=1 in the same cycle M+1. A new request can be accepted at edge M+1, giving one turnaround cycle.
- Read early termination: an `RLAST` that arrives before len+1 beats still ends the transaction; it sets `err` when enabled.
- Read excess beats: if beat len+1 arrives without `RLAST`, the block stays in R until `RLAST`.
- Write data: a `wd_valid` gap inserts a gap on W; `WVALID` is never asserted without data.
- Reset asserted mid-transaction: all outputs clear asynchronously and the state returns to IDLE. The interconnect is reset on the same `rst_n`.

## Configuration
- Macro: `AXI_BURST_MASTER_ERR_EN`.
- When defined:
  - `err` is a sticky flag, cleared by reset and by the next request acceptance.
  - It is set by any `RRESP`≠OKAY, any `BRESP`≠OKAY, or an `RLAST` beat-count mismatch.
  - `done` still pulses when the transaction ends with an error.
- When undefined: `err` is tied to 0 and `RRESP`/`BRESP` are ignored.

## Test plan
- Single read:
  - Stimulus: req read addr 0x0000_0100, len 0; slave returns RDATA 0xDEADBEEF with RLAST.
  - Required: ARADDR 0x100 and ARLEN 0; `rd_data` 0xDEADBEEF with `rd_last`=1; `done` pulse; `err`=0.
- 4-beat read with backpressure:
  - Stimulus: len 3; `rd_ready` low for 2 cycles on beat 1.
  - Required: RREADY follows `rd_ready`; 4 beats received in order; `done` is 1 cycle after the RLAST handshake.
- 2-beat write:
  - Stimulus: addr 0x2000, len 1; data 0x11223344/strb 4'b1111, then 0xAABBCCDD/strb 4'b0011.
  - Required: AWLEN 1; WLAST only on beat 2; WSTRB passed unchanged; `done` after BVALID.
- Slow slave:
  - Stimulus: AWREADY delayed 5 cycles; `wd_valid` is high early.
  - Required: no W handshake before the AW handshake; AWADDR/AWVALID stay stable throughout.
- Error reporting (ERR_EN):
  - Stimulus: BRESP=SLVERR on a write.
  - Required: `err`=1 after B; `err` cleared at the next request acceptance.
  - Stimulus: RLAST on beat 2 of a len-3 read.
  - Required: `err`=1 and return to IDLE.
- Reset mid-burst:
  - Stimulus: `rst_n` low during beat 2 of a 4-beat write.
  - Required: WVALID/`wd_ready` drop immediately; `req_ready`=1 on the first cycle after release.
